// File: rtl/if_pc_branch_unit_pkg.sv
// ---------------------------------------------------------------------------
// if_pc_branch_unit_pkg
//   Shared definitions for the fetch-stage PC / branch unit:
//     fetchState_t     - fetch FSM states (FETCH, DISCARD)
//     PC_INCR          - sequential PC increment (one 32-bit instruction)
//     DEFAULT_RESET_PC - default value loaded into the PC on reset
//   Optional feature macro used by this slice: BRANCH_DELAY_SLOT_EN
// ---------------------------------------------------------------------------
package if_pc_branch_unit_pkg;

   typedef enum logic {
      FETCH   = 1'b0,
      DISCARD = 1'b1
   } fetchState_t;

   localparam logic [31:0] PC_INCR          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_next_pc_mux.sv
// ---------------------------------------------------------------------------
// if_next_pc_mux
//   Purely combinational next-PC selector. Computes the branch and jump
//   targets and picks the highest-priority source:
//   taken branch > jump > sequential (PC + 4).
//   Also produces the raw redirect flush requests; the top qualifies them
//   with reset.
//
//   Configuration macro: BRANCH_DELAY_SLOT_EN
//     defined   : taken branch flushes IF/ID only, jump flushes nothing
//     undefined : taken branch flushes IF/ID and ID/EX, jump flushes IF/ID
//
//   Ports:
//     branchEx, bneEx, zeroEx  in   branch in EX, BNE sense, ALU zero flag
//     pcPlus4Ex                in   branch instruction's PC + 4
//     offsetEx                 in   sign-extended immediate << 2
//     jumpId                   in   J-type jump in ID
//     jumpTargetId             in   26-bit jump index
//     pcPlus4Id                in   jump instruction's PC + 4
//     pcPlus4If                in   current fetch PC + 4
//     taken                    out  branch condition resolved as taken
//     redirect                 out  taken branch or jump present
//     nextPc                   out  selected next PC
//     flushIfId, flushIdEx     out  flush requests caused by the redirect
// ---------------------------------------------------------------------------
module if_next_pc_mux
   import if_pc_branch_unit_pkg::*;
(
   input  logic        branchEx,
   input  logic        bneEx,
   input  logic        zeroEx,
   input  logic [31:0] pcPlus4Ex,
   input  logic [31:0] offsetEx,
   input  logic        jumpId,
   input  logic [25:0] jumpTargetId,
   input  logic [31:0] pcPlus4Id,
   input  logic [31:0] pcPlus4If,
   output logic        taken,
   output logic        redirect,
   output logic [31:0] nextPc,
   output logic        flushIfId,
   output logic        flushIdEx
);

   logic [31:0] branchTarget;
   logic [31:0] jumpTarget;

   // Target arithmetic. The branch add wraps modulo 2^32 on purpose; there
   // is no overflow reporting on address computation. The jump target keeps
   // the upper nibble of the jump's own PC + 4 (region-relative jump).
   always_comb begin
      branchTarget = pcPlus4Ex + offsetEx;
      jumpTarget   = {pcPlus4Id[31:28], jumpTargetId, 2'b00};
      taken        = branchEx & (zeroEx ^ bneEx);
      redirect     = taken | jumpId;
   end

   // Priority selection. A branch in EX is older than a jump in ID, so when
   // both are present the jump is on the wrong path and the branch wins.
   always_comb begin
      nextPc = pcPlus4If;
      if (taken) begin
         nextPc = branchTarget;
      end else if (jumpId) begin
         nextPc = jumpTarget;
      end
   end

   // Flush requests raised by a redirect. With delay slots the instruction
   // behind a branch (already in ID) must survive, so only IF/ID is killed,
   // and a jump's delay slot is the instruction being fetched, so a jump
   // kills nothing. Without delay slots everything younger than the
   // redirecting instruction is squashed.
   always_comb begin
      flushIfId = 1'b0;
      flushIdEx = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
      flushIfId = taken;
`else
      flushIfId = taken | jumpId;
      flushIdEx = taken;
`endif
   end

endmodule

// File: rtl/if_pc_branch_unit.sv
// ---------------------------------------------------------------------------
// if_pc_branch_unit
//   Fetch-stage program counter with branch / jump redirection and a small
//   FETCH/DISCARD FSM that throws away a fetch that was already in flight
//   when a redirect happened and the instruction memory was not yet ready.
//
//   Configuration macro: BRANCH_DELAY_SLOT_EN (changes the flush pattern,
//   see if_next_pc_mux).
//
//   Parameters:
//     RESET_PC                     PC value loaded on reset
//   Ports:
//     Clk                          in   clock, rising edge
//     Reset                        in   synchronous active-high reset
//     Stall_IF                     in   hazard hold of sequential advance
//     Branch_EX, Bne_EX, Zero_EX   in   branch in EX, BNE sense, zero flag
//     PC_Plus_4_EX                 in   branch instruction's PC + 4
//     Instruction_Shift_Left_2_EX  in   branch offset (imm << 2)
//     Jump_ID, Jump_Target_ID      in   J-type jump in ID and its index
//     PC_Plus_4_ID                 in   jump instruction's PC + 4
//     IMem_Ready                   in   instruction memory completes fetch
//     PC_IF, PC_Plus_4_IF          out  current fetch PC and PC + 4
//     IMem_Req                     out  fetch request
//     Flush_IF_ID, Flush_ID_EX     out  pipeline register flush pulses
//     Branch_Taken                 out  branch in EX resolved as taken
// ---------------------------------------------------------------------------
module if_pc_branch_unit
   import if_pc_branch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall_IF,
   input  logic        Branch_EX,
   input  logic        Bne_EX,
   input  logic        Zero_EX,
   input  logic [31:0] PC_Plus_4_EX,
   input  logic [31:0] Instruction_Shift_Left_2_EX,
   input  logic        Jump_ID,
   input  logic [25:0] Jump_Target_ID,
   input  logic [31:0] PC_Plus_4_ID,
   input  logic        IMem_Ready,
   output logic [31:0] PC_IF,
   output logic [31:0] PC_Plus_4_IF,
   output logic        IMem_Req,
   output logic        Flush_IF_ID,
   output logic        Flush_ID_EX,
   output logic        Branch_Taken
);

   fetchState_t state;
   fetchState_t nextState;
   logic [31:0] pcReg;
   logic [31:0] pcNext;
   logic [31:0] pcPlus4;
   logic [31:0] muxPc;
   logic        taken;
   logic        redirect;
   logic        redirectFlushIfId;
   logic        redirectFlushIdEx;
   logic        discardFlush;

   assign pcPlus4 = pcReg + PC_INCR;

   if_next_pc_mux nextPcMux (
      .branchEx     (Branch_EX),
      .bneEx        (Bne_EX),
      .zeroEx       (Zero_EX),
      .pcPlus4Ex    (PC_Plus_4_EX),
      .offsetEx     (Instruction_Shift_Left_2_EX),
      .jumpId       (Jump_ID),
      .jumpTargetId (Jump_Target_ID),
      .pcPlus4Id    (PC_Plus_4_ID),
      .pcPlus4If    (pcPlus4),
      .taken        (taken),
      .redirect     (redirect),
      .nextPc       (muxPc),
      .flushIfId    (redirectFlushIfId),
      .flushIdEx    (redirectFlushIdEx)
   );

   // State and PC register. Reset wins over everything, including a
   // redirect in the same cycle, and drops any pending discard so no stale
   // flush pulse appears after release.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= FETCH;
         pcReg <= RESET_PC;
      end else begin
         state <= nextState;
         pcReg <= pcNext;
      end
   end

   // Next-state / next-PC logic.
   // FETCH: a redirect always loads its target (a stall cannot block it).
   //   If memory was not ready the fetch of the old PC is still in flight,
   //   so we go to DISCARD to drop it when it finally completes. Without a
   //   redirect the PC only moves on a completed, unstalled fetch.
   // DISCARD: the PC already points at the target and holds; the completing
   //   stale fetch is flushed and we return to FETCH. A further redirect
   //   replaces the target and keeps us discarding.
   always_comb begin
      nextState    = state;
      pcNext       = pcReg;
      discardFlush = 1'b0;
      case (state)
         FETCH: begin
            if (redirect) begin
               pcNext = muxPc;
               if (!IMem_Ready) begin
                  nextState = DISCARD;
               end
            end else if (IMem_Ready && !Stall_IF) begin
               pcNext = pcPlus4;
            end
         end
         DISCARD: begin
            discardFlush = IMem_Ready;
            if (redirect) begin
               pcNext    = muxPc;
               nextState = DISCARD;
            end else if (IMem_Ready) begin
               nextState = FETCH;
            end
         end
      endcase
   end

   // Outputs. Flushes are combinational pulses in the cycle the redirect
   // (or discard completion) is decided and are suppressed under reset.
   // Branch_Taken is the raw branch condition.
   always_comb begin
      PC_IF        = pcReg;
      PC_Plus_4_IF = pcPlus4;
      IMem_Req     = ~Reset;
      Branch_Taken = taken;
      Flush_IF_ID  = ~Reset & (redirectFlushIfId | discardFlush);
      Flush_ID_EX  = ~Reset & redirectFlushIdEx;
   end

endmodule

// File: tb/tb_if_pc_branch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_pc_branch_unit
//   Self-checking bench for if_pc_branch_unit. A behavioural model (current
//   PC plus a "discard pending" flag) predicts outputs each cycle; directed
//   scenarios also compare against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_if_pc_branch_unit;

   localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
`ifdef BRANCH_DELAY_SLOT_EN
   localparam bit DELAY_SLOT = 1'b1;
`else
   localparam bit DELAY_SLOT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, stallIf, branchEx, bneEx, zeroEx, jumpId, imemReady;
   logic [31:0] pcPlus4Ex, offsetEx, pcPlus4Id;
   logic [25:0] jumpTargetId;
   logic [31:0] pcIf, pcPlus4If;
   logic        imemReq, flushIfId, flushIdEx, branchTaken;

   int errorCount = 0;
   int checkCount = 0;

   logic [31:0] modelPc;
   bit          modelDiscarding;
   logic [31:0] expPc;
   logic        expReq, expTaken, expFlushIfId, expFlushIdEx;

   if_pc_branch_unit #(.RESET_PC(TB_RESET_PC)) dut (
      .Clk                         (clk),
      .Reset                       (reset),
      .Stall_IF                    (stallIf),
      .Branch_EX                   (branchEx),
      .Bne_EX                      (bneEx),
      .Zero_EX                     (zeroEx),
      .PC_Plus_4_EX                (pcPlus4Ex),
      .Instruction_Shift_Left_2_EX (offsetEx),
      .Jump_ID                     (jumpId),
      .Jump_Target_ID              (jumpTargetId),
      .PC_Plus_4_ID                (pcPlus4Id),
      .IMem_Ready                  (imemReady),
      .PC_IF                       (pcIf),
      .PC_Plus_4_IF                (pcPlus4If),
      .IMem_Req                    (imemReq),
      .Flush_IF_ID                 (flushIfId),
      .Flush_ID_EX                 (flushIdEx),
      .Branch_Taken                (branchTaken)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Drive one cycle's inputs on the falling edge, then let them settle.
   task automatic applyStimulus(input logic rst, input logic stall,
                                input logic br, input logic bne, input logic zero,
                                input logic [31:0] pc4Ex, input logic [31:0] off,
                                input logic jmp, input logic [25:0] jTgt,
                                input logic [31:0] pc4Id, input logic rdy);
      @(negedge clk);
      reset = rst; stallIf = stall; branchEx = br; bneEx = bne; zeroEx = zero;
      pcPlus4Ex = pc4Ex; offsetEx = off; jumpId = jmp; jumpTargetId = jTgt;
      pcPlus4Id = pc4Id; imemReady = rdy;
      #1;
   endtask

   // Quiet cycle: no branch, no jump, random don't-care data.
   task automatic applyQuiet(input logic stall, input logic rdy);
      applyStimulus(1'b0, stall, 1'b0, 1'b0, 1'b0, $urandom, $urandom,
                    1'b0, 26'($urandom), $urandom, rdy);
   endtask

   // Model prediction of this cycle's outputs from the spec's rules.
   function automatic void predict();
      bit isTaken;
      bit wantIfId, wantIdEx;
      isTaken = branchEx && (zeroEx != bneEx);
      if (DELAY_SLOT) begin
         wantIfId = isTaken;
         wantIdEx = 1'b0;
      end else begin
         wantIfId = isTaken || jumpId;
         wantIdEx = isTaken;
      end
      expPc        = modelPc;
      expTaken     = isTaken;
      expReq       = !reset;
      expFlushIfId = !reset && (wantIfId || (modelDiscarding && imemReady));
      expFlushIdEx = !reset && wantIdEx;
   endfunction

   // Advance the model across one rising edge.
   task automatic clockEdge();
      bit isTaken;
      @(posedge clk);
      isTaken = branchEx && (zeroEx != bneEx);
      if (reset) begin
         modelPc = TB_RESET_PC;
         modelDiscarding = 1'b0;
      end else if (isTaken || jumpId) begin
         modelPc = isTaken ? pcPlus4Ex + offsetEx
                           : {pcPlus4Id[31:28], jumpTargetId, 2'b00};
         modelDiscarding = modelDiscarding || !imemReady;
      end else if (modelDiscarding) begin
         if (imemReady) modelDiscarding = 1'b0;
      end else if (imemReady && !stallIf) begin
         modelPc = modelPc + 32'd4;
      end
   endtask

   task automatic test_reset();
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h40,
                    1'b1, 26'h1, 32'h0, 1'b1);
      clockEdge();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h40,
                       1'b1, 26'h1, 32'h0, 1'b1);
         predict();
         checkCount++;
         if (pcIf !== TB_RESET_PC || pcPlus4If !== TB_RESET_PC + 32'd4) begin
            errorCount++;
            $display("[TB] FAIL reset_pc: got pc=%h pc4=%h, want pc=%h pc4=%h",
                     pcIf, pcPlus4If, TB_RESET_PC, TB_RESET_PC + 32'd4);
         end
         checkCount++;
         if ({imemReq, flushIfId, flushIdEx, branchTaken} !== 4'b0001) begin
            errorCount++;
            $display("[TB] FAIL reset_ctl: got req/fif/fex/tk=%b%b%b%b, want 0001",
                     imemReq, flushIfId, flushIdEx, branchTaken);
         end
         clockEdge();
      end
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 4; i++) begin
         applyQuiet(1'b0, 1'b1);
         checkCount++;
         if (pcIf !== 32'(i * 4) || imemReq !== 1'b1 || flushIfId !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL seq_pc[%0d]: got pc=%h req=%b fif=%b, want pc=%h req=1 fif=0",
                     i, pcIf, imemReq, flushIfId, 32'(i * 4));
         end
         clockEdge();
      end
   endtask

   task automatic test_branch();
      // Stall asserted on purpose: a redirect must not be blocked by it.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'hFFFF_FFF0,
                    1'b0, 26'h0, 32'h0, 1'b1);
      checkCount++;
      if (branchTaken !== 1'b1 || flushIfId !== 1'b1 || flushIdEx !== !DELAY_SLOT) begin
         errorCount++;
         $display("[TB] FAIL branch_flush: got tk=%b fif=%b fex=%b, want tk=1 fif=1 fex=%b",
                  branchTaken, flushIfId, flushIdEx, !DELAY_SLOT);
      end
      clockEdge();
      applyQuiet(1'b0, 1'b1);
      checkCount++;
      if (pcIf !== 32'h0000_00F0 || flushIfId !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL branch_target: got pc=%h fif=%b, want pc=000000f0 fif=0",
                  pcIf, flushIfId);
      end
      clockEdge();
      // BNE with zero set is not taken.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h500, 32'h10,
                    1'b0, 26'h0, 32'h0, 1'b1);
      checkCount++;
      if (branchTaken !== 1'b0 || flushIfId !== 1'b0 || flushIdEx !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL bne_not_taken: got tk=%b fif=%b fex=%b, want 0 0 0",
                  branchTaken, flushIfId, flushIdEx);
      end
      clockEdge();
   endtask

   task automatic test_jump();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 26'h000_0040, 32'h4000_0010, 1'b1);
      checkCount++;
      if (flushIfId !== !DELAY_SLOT || flushIdEx !== 1'b0 || branchTaken !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL jump_flush: got fif=%b fex=%b tk=%b, want fif=%b fex=0 tk=0",
                  flushIfId, flushIdEx, branchTaken, !DELAY_SLOT);
      end
      clockEdge();
      applyQuiet(1'b0, 1'b1);
      checkCount++;
      if (pcIf !== 32'h4000_0100) begin
         errorCount++;
         $display("[TB] FAIL jump_target: got pc=%h, want 40000100", pcIf);
      end
      clockEdge();
   endtask

   task automatic test_discard();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h20,
                    1'b0, 26'h0, 32'h0, 1'b0);
      clockEdge();
      applyQuiet(1'b0, 1'b0);
      checkCount++;
      if (pcIf !== 32'h220 || flushIfId !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL discard_wait: got pc=%h fif=%b, want pc=00000220 fif=0",
                  pcIf, flushIfId);
      end
      clockEdge();
      applyQuiet(1'b0, 1'b1);
      checkCount++;
      if (pcIf !== 32'h220 || flushIfId !== 1'b1 || flushIdEx !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL discard_flush: got pc=%h fif=%b fex=%b, want pc=00000220 fif=1 fex=0",
                  pcIf, flushIfId, flushIdEx);
      end
      clockEdge();
      applyQuiet(1'b0, 1'b1);
      checkCount++;
      if (pcIf !== 32'h220 || flushIfId !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL discard_return: got pc=%h fif=%b, want pc=00000220 fif=0",
                  pcIf, flushIfId);
      end
      clockEdge();
      applyQuiet(1'b0, 1'b1);
      checkCount++;
      if (pcIf !== 32'h224) begin
         errorCount++;
         $display("[TB] FAIL discard_advance: got pc=%h, want 00000224", pcIf);
      end
      clockEdge();
   endtask

   task automatic test_reset_in_discard();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 32'h0,
                    1'b0, 26'h0, 32'h0, 1'b0);
      clockEdge();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 26'h0, 32'h0, 1'b0);
      clockEdge();
      applyQuiet(1'b0, 1'b1);
      checkCount++;
      if (pcIf !== TB_RESET_PC || flushIfId !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL reset_discard: got pc=%h fif=%b, want pc=%h fif=0",
                  pcIf, flushIfId, TB_RESET_PC);
      end
      clockEdge();
   endtask

   task automatic test_wrap_and_priority();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 26'h3FF_FFFF, 32'hF000_0000, 1'b1);
      clockEdge();
      applyQuiet(1'b0, 1'b1);
      checkCount++;
      if (pcIf !== 32'hFFFF_FFFC || pcPlus4If !== 32'h0000_0000) begin
         errorCount++;
         $display("[TB] FAIL wrap_pc4: got pc=%h pc4=%h, want fffffffc 00000000",
                  pcIf, pcPlus4If);
      end
      clockEdge();
      applyQuiet(1'b1, 1'b1);
      checkCount++;
      if (pcIf !== 32'h0) begin
         errorCount++;
         $display("[TB] FAIL wrap_pc: got pc=%h, want 00000000", pcIf);
      end
      clockEdge();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1000, 32'h8,
                    1'b1, 26'h123, 32'h0, 1'b1);
      checkCount++;
      if (pcIf !== 32'h0 || flushIdEx !== !DELAY_SLOT) begin
         errorCount++;
         $display("[TB] FAIL stall_hold: got pc=%h fex=%b, want pc=00000000 fex=%b",
                  pcIf, flushIdEx, !DELAY_SLOT);
      end
      clockEdge();
      applyQuiet(1'b0, 1'b1);
      checkCount++;
      if (pcIf !== 32'h1008) begin
         errorCount++;
         $display("[TB] FAIL branch_over_jump: got pc=%h, want 00001008", pcIf);
      end
      clockEdge();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom),
                       $urandom, $urandom, ($urandom_range(0, 5) == 0),
                       26'($urandom), $urandom, ($urandom_range(0, 2) != 0));
         predict();
         checkCount++;
         if (pcIf !== expPc || pcPlus4If !== expPc + 32'd4) begin
            errorCount++;
            $display("[TB] FAIL rand_pc[%0d]: got pc=%h pc4=%h, want pc=%h pc4=%h",
                     i, pcIf, pcPlus4If, expPc, expPc + 32'd4);
         end
         checkCount++;
         if ({imemReq, branchTaken, flushIfId, flushIdEx} !==
             {expReq, expTaken, expFlushIfId, expFlushIdEx}) begin
            errorCount++;
            $display("[TB] FAIL rand_ctl[%0d]: got req/tk/fif/fex=%b%b%b%b, want %b%b%b%b",
                     i, imemReq, branchTaken, flushIfId, flushIdEx,
                     expReq, expTaken, expFlushIfId, expFlushIdEx);
         end
         clockEdge();
      end
   endtask

   // Scenario sequence.
   initial begin
      modelPc = TB_RESET_PC;
      modelDiscarding = 1'b0;
      test_reset();
      test_sequential();
      test_branch();
      test_jump();
      test_discard();
      test_reset_in_discard();
      test_wrap_and_priority();
      test_random();
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/if_pc_branch_unit.md
IF_PC_BRANCH_UNIT -- requirements
Module: if_pc_branch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The module SHALL have port Clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port Reset, input, 1 bit, synchronous active-high reset sampled on the rising edge of Clk.
REQ-004 The module SHALL have port Stall_IF, input, 1 bit, hazard hold that freezes sequential PC advance.
REQ-005 The module SHALL have ports Branch_EX, Bne_EX and Zero_EX, each input, 1 bit: branch in EX, BNE sense, and ALU zero flag.
REQ-006 The module SHALL have port PC_Plus_4_EX, input, 32 bits, the branch instruction's PC+4.
REQ-007 The module SHALL have port Instruction_Shift_Left_2_EX, input, 32 bits, the sign-extended immediate already shifted left by 2.
REQ-008 The module SHALL have ports Jump_ID (input, 1 bit), Jump_Target_ID (input, 26 bits) and PC_Plus_4_ID (input, 32 bits), carrying the J-type jump in ID.
REQ-009 The module SHALL have port IMem_Ready, input, 1 bit, indicating the instruction memory accepts or completes the current fetch.
REQ-010 The module SHALL have outputs PC_IF and PC_Plus_4_IF, each 32 bits, the current fetch PC and that PC plus 4.
REQ-011 The module SHALL have outputs IMem_Req, Flush_IF_ID, Flush_ID_EX and Branch_Taken, each 1 bit.

Function
REQ-012 Taken SHALL equal Branch_EX & (Zero_EX ^ Bne_EX), and Branch_Taken SHALL be that value driven combinationally.
REQ-013 The branch target SHALL equal PC_Plus_4_EX + Instruction_Shift_Left_2_EX, modulo 2^32 with wrap and no overflow flag.
REQ-014 The jump target SHALL equal {PC_Plus_4_ID[31:28], Jump_Target_ID, 2'b00}.
REQ-015 PC_Plus_4_IF SHALL equal PC_IF + 4 modulo 2^32, so 32'hFFFF_FFFC yields 32'h0000_0000.
REQ-016 The FSM SHALL have two states, FETCH and DISCARD, and IMem_Req SHALL be 1 in both states whenever Reset is low.
REQ-017 The next-PC priority SHALL be: taken branch, then jump, then sequential.
REQ-018 A taken branch or jump SHALL load PC_IF with its target in the next cycle regardless of Stall_IF.
REQ-019 In FETCH, with no redirect, PC_IF SHALL advance to PC_Plus_4_IF only when IMem_Ready=1 and Stall_IF=0, and SHALL otherwise hold.
REQ-020 A redirect while in FETCH with IMem_Ready=0 SHALL still load the target and SHALL move the FSM to DISCARD.
REQ-021 In DISCARD, PC_IF SHALL hold and the fetch completing with IMem_Ready=1 SHALL be discarded (Flush_IF_ID=1 that cycle); the FSM SHALL then return to FETCH.
REQ-022 A new taken branch arriving while in DISCARD SHALL overwrite PC_IF with the new target and SHALL keep the FSM in DISCARD.
REQ-023 Simultaneous taken branch and Jump_ID SHALL select the branch and flush the jump, since the jump is on the wrong path.
REQ-024 The flush outputs SHALL be combinational one-cycle pulses coincident with the redirect decision.

Reset
REQ-025 On Reset=1 the block SHALL set PC_IF=RESET_PC, PC_Plus_4_IF=RESET_PC+4, FSM=FETCH, and IMem_Req=0 for that cycle.
REQ-026 Reset SHALL dominate any redirect in the same cycle.
REQ-027 Reset asserted while in DISCARD SHALL abandon the pending discard and SHALL NOT produce a flush pulse after release.

Configuration
REQ-028 The feature macro SHALL be named BRANCH_DELAY_SLOT_EN.
REQ-029 With BRANCH_DELAY_SLOT_EN defined, a taken branch SHALL assert Flush_IF_ID only, preserving the delay slot in ID/EX.
REQ-030 With BRANCH_DELAY_SLOT_EN defined, a jump SHALL assert no flush.
REQ-031 Without BRANCH_DELAY_SLOT_EN, a taken branch SHALL assert both Flush_IF_ID and Flush_ID_EX, and a jump SHALL assert Flush_IF_ID.

Structure
REQ-032 A shared package SHALL hold the FSM state typedef (FETCH, DISCARD), the constant PC_INCR=4, and the RESET_PC default.
REQ-033 The design SHALL contain one sub-module, if_next_pc_mux, which is combinational and performs target computation and priority selection; the FSM and PC register SHALL stay in the top module.

Verification
REQ-034 Reset with RESET_PC=0, then IMem_Ready=1 for 3 cycles SHALL give PC_IF sequence 0, 4, 8, 12.
REQ-035 Branch_EX=1, Zero_EX=1, Bne_EX=0, PC_Plus_4_EX=0x100, offset 0xFFFF_FFF0 SHALL give PC_IF=0xF0 next cycle and Branch_Taken=1; flush pattern SHALL match the macro setting.
REQ-036 Jump_ID=1, PC_Plus_4_ID=0x4000_0010, Jump_Target_ID=0x000_0040 SHALL give PC_IF=0x4000_0100.
REQ-037 A taken branch with IMem_Ready=0 SHALL enter DISCARD; IMem_Ready=1 two cycles later SHALL give one Flush_IF_ID pulse, then FETCH at the target.
REQ-038 PC_IF=0xFFFF_FFFC with IMem_Ready=1 SHALL wrap to 0, and Stall_IF=1 SHALL hold PC_IF; simultaneous branch and jump SHALL load the branch target.
